// File: rtl/insight_retire_trace_buffer_if.sv
// Bundles the retire, trace-sink and shadow-register read signals of the
// Insight retirement trace buffer. The core/sink side uses master and the buffer uses slave.
interface insight_retire_trace_buffer_if #(
    parameter int XLEN = 32,
    parameter int NRET = 2,
    parameter int RW   = 5
);
    logic                 enable;
    logic [NRET-1:0]      in_valid;
    logic [NRET*XLEN-1:0] in_pc;
    logic [NRET-1:0]      in_wen;
    logic [NRET*RW-1:0]   in_rd;
    logic [NRET*XLEN-1:0] in_wdata;
    logic                 in_stall;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [XLEN-1:0]      out_wdata;
    logic                 out_wen;
    logic [RW-1:0]        out_rd;
    logic [15:0]          out_seq;
    logic                 out_gap;
    logic [15:0]          drop_count;

    logic [RW-1:0]        reg_rd_addr;
    logic [XLEN-1:0]      reg_rd_data;

    modport master (
        output enable, in_valid, in_pc, in_wen, in_rd, in_wdata, out_ready, reg_rd_addr,
        input  in_stall, out_valid, out_pc, out_wdata, out_wen, out_rd, out_seq, out_gap,
               drop_count, reg_rd_data
    );

    modport slave (
        input  enable, in_valid, in_pc, in_wen, in_rd, in_wdata, out_ready, reg_rd_addr,
        output in_stall, out_valid, out_pc, out_wdata, out_wen, out_rd, out_seq, out_gap,
               drop_count, reg_rd_data
    );
endinterface

// File: rtl/insight_retire_trace_buffer.sv
// Retirement trace capture: compacts up to NRET retire events per cycle into an
// in-order FIFO tagged with sequence numbers and gap flags, and keeps a shadow register file.
module insight_retire_trace_buffer #(
    parameter int XLEN          = 32,
    parameter int NREGS         = 32,
    parameter int NRET          = 2,
    parameter int DEPTH         = 8,
    parameter int STALL_ON_FULL = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    insight_retire_trace_buffer_if.slave  bus
);
    localparam int RW = $clog2(NREGS);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_memPc    [DEPTH];
    logic [XLEN-1:0] r_memWdata [DEPTH];
    logic            r_memWen   [DEPTH];
    logic [RW-1:0]   r_memRd    [DEPTH];
    logic [15:0]     r_memSeq   [DEPTH];
    logic            r_memGap   [DEPTH];

    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_seq;
    logic [15:0]     r_dropCount;
    logic            r_pendingGap;
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    logic [CW-1:0]   w_free;
    logic [CW-1:0]   w_k;
    logic [CW-1:0]   w_pushCount;
    logic [CW-1:0]   w_lost;
    logic [CW-1:0]   w_dropped;
    logic [CW-1:0]   w_slot [NRET];
    logic [NRET-1:0] w_push;
    logic            w_pop;
    logic [16:0]     w_dropSum;

    // Compacted slot of each valid channel; only the first 'free' slots are accepted.
    always_comb begin
        w_free = CW'(DEPTH) - r_count;
        w_k    = '0;
        w_push = '0;
        for (int i = 0; i < NRET; i++) begin
            w_slot[i] = w_k;
            if (bus.in_valid[i]) begin
                w_push[i] = bus.enable && (w_k < w_free);
                w_k       = w_k + CW'(1);
            end
        end
        w_pushCount = !bus.enable ? '0 : ((w_k < w_free) ? w_k : w_free);
        w_lost      = w_k - w_pushCount;
        w_dropped   = bus.enable ? w_lost : '0;
    end

    assign w_pop     = (r_count != '0) && bus.out_ready;
    assign w_dropSum = {1'b0, r_dropCount} + 17'(w_dropped);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_seq        <= '0;
            r_dropCount  <= '0;
            r_pendingGap <= 1'b0;
        end else begin
            r_head      <= r_head + AW'(w_pop);
            r_tail      <= r_tail + AW'(w_pushCount);
            r_count     <= r_count + w_pushCount - CW'(w_pop);
            r_seq       <= r_seq + 16'(w_k);
            r_dropCount <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
            // Lost events land after this cycle's pushes, so they mark the next push.
            if (w_lost != '0) begin
                r_pendingGap <= 1'b1;
            end else if (w_pushCount != '0) begin
                r_pendingGap <= 1'b0;
            end
        end
    end

    // Entry storage needs no reset: the head fields are masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NRET; i++) begin
                if (w_push[i]) begin
                    r_memPc[r_tail + AW'(w_slot[i])]    <= bus.in_pc[i*XLEN +: XLEN];
                    r_memWdata[r_tail + AW'(w_slot[i])] <= bus.in_wdata[i*XLEN +: XLEN];
                    r_memWen[r_tail + AW'(w_slot[i])]   <= bus.in_wen[i];
                    r_memRd[r_tail + AW'(w_slot[i])]    <= bus.in_rd[i*RW +: RW];
                    r_memSeq[r_tail + AW'(w_slot[i])]   <= r_seq + 16'(w_slot[i]);
                    r_memGap[r_tail + AW'(w_slot[i])]   <= r_pendingGap && (w_slot[i] == '0);
                end
            end
        end
    end

    // Later channels are younger, so iterating upward lets the highest index win.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 1; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NRET; i++) begin
                if (bus.in_valid[i] && bus.in_wen[i] && (bus.in_rd[i*RW +: RW] != '0)) begin
                    r_regs[bus.in_rd[i*RW +: RW]] <= bus.in_wdata[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        bus.reg_rd_data = '0;
        if (bus.reg_rd_addr != '0) begin
            bus.reg_rd_data = r_regs[bus.reg_rd_addr];
        end
    end

    assign bus.out_valid  = (r_count != '0);
    assign bus.drop_count = r_dropCount;
    assign bus.in_stall   = (STALL_ON_FULL != 0) && (w_free < CW'(NRET));

    always_comb begin
        bus.out_pc    = '0;
        bus.out_wdata = '0;
        bus.out_wen   = 1'b0;
        bus.out_rd    = '0;
        bus.out_seq   = '0;
        bus.out_gap   = 1'b0;
        if (bus.out_valid) begin
            bus.out_pc    = r_memPc[r_head];
            bus.out_wdata = r_memWdata[r_head];
            bus.out_wen   = r_memWen[r_head];
            bus.out_rd    = r_memRd[r_head];
            bus.out_seq   = r_memSeq[r_head];
            bus.out_gap   = r_memGap[r_head];
        end
    end
endmodule

// File: tb/tb_insight_retire_trace_buffer.sv
// Scoreboard bench for insight_retire_trace_buffer: a drop-mode instance is fully checked,
// a stall-mode twin sharing the same stimulus is watched for in_stall.
module tb_insight_retire_trace_buffer;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRET  = 2;
    localparam int DEPTH = 8;
    localparam int RW    = 5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wdata;
        logic        wen;
        logic [4:0]  rd;
        logic [15:0] seq;
        logic        gap;
    } entry_t;

    logic   clock = 1'b0;
    logic   reset = 1'b1;
    entry_t sbq[$];
    entry_t expE;
    int     checks = 0;
    int     errors = 0;

    always #5 clock = ~clock;

    insight_retire_trace_buffer_if #(.XLEN(XLEN), .NRET(NRET), .RW(RW)) bus ();
    insight_retire_trace_buffer_if #(.XLEN(XLEN), .NRET(NRET), .RW(RW)) bus2 ();

    assign bus2.enable      = bus.enable;
    assign bus2.in_valid    = bus.in_valid;
    assign bus2.in_pc       = bus.in_pc;
    assign bus2.in_wen      = bus.in_wen;
    assign bus2.in_rd       = bus.in_rd;
    assign bus2.in_wdata    = bus.in_wdata;
    assign bus2.out_ready   = bus.out_ready;
    assign bus2.reg_rd_addr = bus.reg_rd_addr;

    insight_retire_trace_buffer #(
        .XLEN(XLEN), .NREGS(NREGS), .NRET(NRET), .DEPTH(DEPTH), .STALL_ON_FULL(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    insight_retire_trace_buffer #(
        .XLEN(XLEN), .NREGS(NREGS), .NRET(NRET), .DEPTH(DEPTH), .STALL_ON_FULL(1)
    ) dutStall (
        .clock(clock),
        .reset(reset),
        .bus(bus2.slave)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        bus.in_valid = '0;
        bus.in_wen   = '0;
        bus.in_pc    = '0;
        bus.in_rd    = '0;
        bus.in_wdata = '0;
    endtask

    task automatic driveEvents(input logic en, input logic [1:0] valid,
                               input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [1:0] wen, input logic [4:0] rd0, input logic [4:0] rd1,
                               input logic [31:0] wd0, input logic [31:0] wd1);
        bus.enable   = en;
        bus.in_valid = valid;
        bus.in_pc    = {pc1, pc0};
        bus.in_wen   = wen;
        bus.in_rd    = {rd1, rd0};
        bus.in_wdata = {wd1, wd0};
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] valid,
                                 input logic [31:0] pc0, input logic [31:0] pc1,
                                 input logic [1:0] wen, input logic [4:0] rd0, input logic [4:0] rd1,
                                 input logic [31:0] wd0, input logic [31:0] wd1);
        driveEvents(en, valid, pc0, pc1, wen, rd0, rd1, wd0, wd1);
        tick();
        idleInputs();
    endtask

    task automatic expectEntry(input logic [31:0] pc, input logic [31:0] wdata, input logic wen,
                               input logic [4:0] rd, input logic [15:0] seq, input logic gap);
        entry_t e;
        e.pc    = pc;
        e.wdata = wdata;
        e.wen   = wen;
        e.rd    = rd;
        e.seq   = seq;
        e.gap   = gap;
        sbq.push_back(e);
    endtask

    task automatic waitDrain(input string name);
        for (int c = 0; c < 64 && sbq.size() != 0; c++) begin
            tick();
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d entries never left, expected 0", name, sbq.size());
        end
        tick();
        checkOutput({name, "Empty"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sbq.delete();
    endtask

    // Monitor: every accepted head is compared against the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedEntry: got pc 0x%0h seq %0d, expected no entry",
                         bus.out_pc, bus.out_seq);
            end else begin
                expE = sbq.pop_front();
                if (bus.out_pc !== expE.pc || bus.out_wdata !== expE.wdata || bus.out_wen !== expE.wen ||
                    bus.out_rd !== expE.rd || bus.out_seq !== expE.seq || bus.out_gap !== expE.gap) begin
                    errors++;
                    $display("[TB] FAIL entry: got pc=%0h wd=%0h wen=%0b rd=%0d seq=%0d gap=%0b, expected pc=%0h wd=%0h wen=%0b rd=%0d seq=%0d gap=%0b",
                             bus.out_pc, bus.out_wdata, bus.out_wen, bus.out_rd, bus.out_seq, bus.out_gap,
                             expE.pc, expE.wdata, expE.wen, expE.rd, expE.seq, expE.gap);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.enable      = 1'b1;
        bus.out_ready   = 1'b0;
        bus.reg_rd_addr = '0;
        idleInputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        bus.reg_rd_addr = 5'd5;
        #1;
        checkOutput("resetOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("resetDropCount", 32'(bus.drop_count), 32'd0);
        checkOutput("resetStall", 32'(bus.in_stall), 32'd0);
        checkOutput("resetStallTwin", 32'(bus2.in_stall), 32'd0);
        checkOutput("resetOutPc", bus.out_pc, 32'd0);
        checkOutput("resetOutSeq", 32'(bus.out_seq), 32'd0);
        checkOutput("resetShadowX5", bus.reg_rd_data, 32'd0);

        // Two events per cycle with the sink always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expectEntry(32'h100 + 32'(8 * i), 32'd0, 1'b0, 5'd0, 16'(2 * i), 1'b0);
            expectEntry(32'h104 + 32'(8 * i), 32'd0, 1'b0, 5'd0, 16'(2 * i + 1), 1'b0);
            applyStimulus(1'b1, 2'b11, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        end
        waitDrain("streamDrain");
        checkOutput("streamDropCount", 32'(bus.drop_count), 32'd0);

        // Overflow in drop mode: 10 events into 8 entries
        doReset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expectEntry(32'h200 + 32'(8 * i), 32'd0, 1'b0, 5'd0, 16'(2 * i), 1'b0);
            expectEntry(32'h204 + 32'(8 * i), 32'd0, 1'b0, 5'd0, 16'(2 * i + 1), 1'b0);
            applyStimulus(1'b1, 2'b11, 32'h200 + 32'(8 * i), 32'h204 + 32'(8 * i), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        end
        applyStimulus(1'b1, 2'b11, 32'h220, 32'h224, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        checkOutput("overflowDropCount", 32'(bus.drop_count), 32'd2);
        checkOutput("overflowOutValid", 32'(bus.out_valid), 32'd1);
        checkOutput("overflowNoStallDropMode", 32'(bus.in_stall), 32'd0);
        bus.out_ready = 1'b1;
        waitDrain("overflowDrain");
        expectEntry(32'h300, 32'd0, 1'b0, 5'd0, 16'd10, 1'b1);
        applyStimulus(1'b1, 2'b01, 32'h300, 32'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        expectEntry(32'h304, 32'd0, 1'b0, 5'd0, 16'd11, 1'b0);
        applyStimulus(1'b1, 2'b10, 32'd0, 32'h304, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        waitDrain("gapDrain");

        // Stall threshold on the back-pressure twin
        doReset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            expectEntry(32'h500 + 32'(4 * i), 32'd0, 1'b0, 5'd0, 16'(i), 1'b0);
            applyStimulus(1'b1, 2'b01, 32'h500 + 32'(4 * i), 32'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
            if (i == 5) begin
                checkOutput("stallLowAtSix", 32'(bus2.in_stall), 32'd0);
            end
        end
        checkOutput("stallHighAtSeven", 32'(bus2.in_stall), 32'd1);
        checkOutput("noStallInDropMode", 32'(bus.in_stall), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("stallFallsAtSix", 32'(bus2.in_stall), 32'd0);
        waitDrain("stallDrain");

        // Shadow register file: same-rd collision, no bypass, x0 stays zero
        bus.reg_rd_addr = 5'd5;
        expectEntry(32'h600, 32'hAAAA, 1'b1, 5'd5, 16'd7, 1'b0);
        expectEntry(32'h604, 32'hBBBB, 1'b1, 5'd5, 16'd8, 1'b0);
        driveEvents(1'b1, 2'b11, 32'h600, 32'h604, 2'b11, 5'd5, 5'd5, 32'hAAAA, 32'hBBBB);
        #1;
        checkOutput("shadowNoBypass", bus.reg_rd_data, 32'd0);
        tick();
        idleInputs();
        checkOutput("shadowHighestWins", bus.reg_rd_data, 32'hBBBB);
        expectEntry(32'h608, 32'h1234, 1'b1, 5'd0, 16'd9, 1'b0);
        expectEntry(32'h60C, 32'h66, 1'b1, 5'd6, 16'd10, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'h608, 32'h60C, 2'b11, 5'd0, 5'd6, 32'h1234, 32'h66);
        bus.reg_rd_addr = 5'd0;
        #1;
        checkOutput("shadowX0", bus.reg_rd_data, 32'd0);
        bus.reg_rd_addr = 5'd6;
        #1;
        checkOutput("shadowX6", bus.reg_rd_data, 32'h66);
        waitDrain("shadowDrain");

        // Suppressed events while capture is disabled
        doReset();
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 2'b01, 32'h700, 32'd0, 2'b01, 5'd1, 5'd0, 32'h11, 32'd0);
        applyStimulus(1'b0, 2'b01, 32'h704, 32'd0, 2'b01, 5'd2, 5'd0, 32'h22, 32'd0);
        applyStimulus(1'b0, 2'b01, 32'h708, 32'd0, 2'b01, 5'd3, 5'd0, 32'h33, 32'd0);
        checkOutput("disabledNoEntry", 32'(bus.out_valid), 32'd0);
        expectEntry(32'h70C, 32'h44, 1'b1, 5'd4, 16'd3, 1'b1);
        applyStimulus(1'b1, 2'b01, 32'h70C, 32'd0, 2'b01, 5'd4, 5'd0, 32'h44, 32'd0);
        waitDrain("disabledDrain");
        checkOutput("disabledDropCount", 32'(bus.drop_count), 32'd0);
        for (int r = 1; r <= 4; r++) begin
            bus.reg_rd_addr = 5'(r);
            #1;
            checkOutput("disabledShadow", bus.reg_rd_data, 32'h11 * 32'(r));
        end

        // Reset with five entries queued
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 2'b11, 32'h800, 32'h804, 2'b11, 5'd7, 5'd8, 32'h77, 32'h88);
        applyStimulus(1'b1, 2'b11, 32'h808, 32'h80C, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        applyStimulus(1'b1, 2'b01, 32'h810, 32'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        bus.reg_rd_addr = 5'd7;
        #1;
        checkOutput("preResetShadowX7", bus.reg_rd_data, 32'h77);
        checkOutput("preResetOutValid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("midResetOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("midResetDropCount", 32'(bus.drop_count), 32'd0);
        checkOutput("midResetShadowX7", bus.reg_rd_data, 32'd0);
        checkOutput("midResetOutPc", bus.out_pc, 32'd0);
        reset = 1'b0;
        sbq.delete();
        bus.out_ready = 1'b1;
        expectEntry(32'h900, 32'd0, 1'b0, 5'd0, 16'd0, 1'b0);
        applyStimulus(1'b1, 2'b01, 32'h900, 32'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        waitDrain("postResetDrain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
